// File: rtl/fal6567_phase_gen_if.sv
// Timing bus between the phase generator and its consumers (VIC core, bus sequencer).
// The generator drives the enables and status; the consumer drives the mode requests.
interface fal6567_phase_gen_if #(
    parameter int NPH = 3
);
    logic           turbo;
    logic           dcrate;
    logic [NPH-1:0] ph_ce;
    logic           cyc_start;
    logic           cyc_end;
    logic           dot_ce;
    logic           turbo_act;
    logic           dcrate_act;
    logic           locked;

    modport master (
        input  turbo, dcrate,
        output ph_ce, cyc_start, cyc_end, dot_ce, turbo_act, dcrate_act, locked
    );

    modport slave (
        output turbo, dcrate,
        input  ph_ce, cyc_start, cyc_end, dot_ce, turbo_act, dcrate_act, locked
    );
endinterface

// File: rtl/fal6567_phase_gen.sv
// Enable-based bus-cycle phase generator with a fractional dot-clock NCO.
// Cycle length and dot rate switch only at cycle / carry boundaries, so no pulse is ever truncated.
module fal6567_phase_gen #(
    parameter int             NPH      = 3,
    parameter int             DIV0     = 28,
    parameter int             DIV1     = 24,
    parameter int             ACCW     = 24,
    parameter logic [ACCW-1:0] INC0    = ACCW'('h400000),
    parameter logic [ACCW-1:0] INC1    = ACCW'('h800000),
    parameter int             LOCK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fal6567_phase_gen_if.master   bus
);

    localparam int DMAX = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam int LW   = (LOCK_CYC > 0) ? $clog2(LOCK_CYC + 1) : 1;

    if (NPH < 1 || NPH > 8 || DIV0 < NPH || DIV1 < NPH) begin : g_param_check
        $error("fal6567_phase_gen: need 1 <= NPH <= 8, DIV0 >= NPH and DIV1 >= NPH");
    end

    // Tap k sits at floor(k*D/NPH); with D >= NPH these offsets are strictly increasing.
    function automatic logic [CW-1:0] tap(input int k, input int d);
        return CW'((k * d) / NPH);
    endfunction

    logic            turbo_s1_q, turbo_s2_q;
    logic            dcrate_s1_q, dcrate_s2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            turbo_act_q, turbo_act_d;
    logic            dcrate_act_q, dcrate_act_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NPH-1:0]  ph_ce_q, ph_ce_d;
    logic            cyc_end_q, cyc_end_d;
    logic            dot_ce_q, dot_ce_d;
    logic            locked_q, locked_d;

    logic [CW-1:0]   last_cnt;
    logic [ACCW:0]   nco_sum;
    logic            carry;
    logic            mode_change;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        last_cnt     = turbo_act_q ? CW'(DIV1 - 1) : CW'(DIV0 - 1);
        cyc_end_d    = (cnt_q == last_cnt);
        cnt_d        = cyc_end_d ? '0 : cnt_q + 1'b1;

        ph_ce_d      = '0;
        for (int k = 0; k < NPH; k++) begin
            ph_ce_d[k] = (cnt_q == (turbo_act_q ? tap(k, DIV1) : tap(k, DIV0)));
        end

        nco_sum      = {1'b0, acc_q} + {1'b0, (dcrate_act_q ? INC1 : INC0)};
        carry        = nco_sum[ACCW];
        acc_d        = nco_sum[ACCW-1:0];
        dot_ce_d     = carry;

        // Mode requests are only honoured on boundaries, which filters short glitches for free.
        turbo_act_d  = cyc_end_d ? turbo_s2_q  : turbo_act_q;
        dcrate_act_d = carry     ? dcrate_s2_q : dcrate_act_q;
        mode_change  = (turbo_act_d != turbo_act_q) || (dcrate_act_d != dcrate_act_q);

        lock_cnt_d   = lock_cnt_q;
        if (mode_change) begin
            lock_cnt_d = '0;
        end else if (cyc_end_d && (lock_cnt_q != LW'(LOCK_CYC))) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        locked_d     = (lock_cnt_d == LW'(LOCK_CYC));
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // The synchronizers are reset too, so no stale request can leak out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turbo_s1_q   <= 1'b0;
            turbo_s2_q   <= 1'b0;
            dcrate_s1_q  <= 1'b0;
            dcrate_s2_q  <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            turbo_act_q  <= 1'b0;
            dcrate_act_q <= 1'b0;
            lock_cnt_q   <= '0;
            ph_ce_q      <= '0;
            cyc_end_q    <= 1'b0;
            dot_ce_q     <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            turbo_s1_q   <= bus.turbo;
            turbo_s2_q   <= turbo_s1_q;
            dcrate_s1_q  <= bus.dcrate;
            dcrate_s2_q  <= dcrate_s1_q;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            turbo_act_q  <= turbo_act_d;
            dcrate_act_q <= dcrate_act_d;
            lock_cnt_q   <= lock_cnt_d;
            ph_ce_q      <= ph_ce_d;
            cyc_end_q    <= cyc_end_d;
            dot_ce_q     <= dot_ce_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.ph_ce      = ph_ce_q;
    assign bus.cyc_start  = ph_ce_q[0];
    assign bus.cyc_end    = cyc_end_q;
    assign bus.dot_ce     = dot_ce_q;
    assign bus.turbo_act  = turbo_act_q;
    assign bus.dcrate_act = dcrate_act_q;
    assign bus.locked     = locked_q;

endmodule

// File: tb/tb_fal6567_phase_gen.sv
// Randomized bench for fal6567_phase_gen: two instances (3-phase default, 4-phase 10/8)
// checked every clk against an arithmetic reference model of cycle position, NCO phase and lock.
module tb_fal6567_phase_gen;

    localparam int     ACCW     = 24;
    localparam longint MODV     = 64'd1 << ACCW;
    localparam longint INC0     = 64'h400000;
    localparam longint INC1     = 64'h800000;
    localparam int     LOCK_CYC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic turbo_r = 1'b0;
    logic dcrate_r = 1'b0;

    always #5 clk = ~clk;

    fal6567_phase_gen_if #(.NPH(3)) bus_a ();
    fal6567_phase_gen_if #(.NPH(4)) bus_b ();

    assign bus_a.turbo  = turbo_r;
    assign bus_a.dcrate = dcrate_r;
    assign bus_b.turbo  = turbo_r;
    assign bus_b.dcrate = dcrate_r;

    fal6567_phase_gen #(.NPH(3), .DIV0(28), .DIV1(24)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    fal6567_phase_gen #(.NPH(4), .DIV0(10), .DIV1(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        int         nph, div0, div1;
        int         pos;      // position inside the current bus cycle
        bit         mode;     // cycle length in effect
        bit         rate;     // dot rate in effect
        longint     phase;    // NCO phase, modulo 2^ACCW
        int         lock;
        bit         t_h1, t_h2, d_h1, d_h2;  // requests seen one / two edges ago
        logic [7:0] ph;
        bit         cs, ce, dot;
    } model_t;

    model_t ma, mb;
    int total = 0;
    int bad = 0;
    int since_cs = 0;
    int since_dot = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(output model_t m, input int nph, input int div0, input int div1);
        m.nph = nph; m.div0 = div0; m.div1 = div1;
        m.pos = 0; m.mode = 0; m.rate = 0; m.phase = 0; m.lock = 0;
        m.t_h1 = 0; m.t_h2 = 0; m.d_h1 = 0; m.d_h2 = 0;
        m.ph = '0; m.cs = 0; m.ce = 0; m.dot = 0;
    endtask

    task automatic model_step(inout model_t m, input bit t_in, input bit d_in);
        int     d;
        longint sum;
        bit     ce, carry, nm, nr;
        d = m.mode ? m.div1 : m.div0;
        m.ph = '0;
        for (int k = 0; k < m.nph; k++)
            if (m.pos == (k * d) / m.nph) m.ph[k] = 1'b1;
        ce    = (m.pos == d - 1);
        sum   = m.phase + (m.rate ? INC1 : INC0);
        carry = (sum >= MODV);
        nm    = ce ? m.t_h2 : m.mode;
        nr    = carry ? m.d_h2 : m.rate;
        if (nm != m.mode || nr != m.rate) m.lock = 0;
        else if (ce && m.lock < LOCK_CYC) m.lock++;
        m.pos   = ce ? 0 : m.pos + 1;
        m.phase = sum % MODV;
        m.mode  = nm;
        m.rate  = nr;
        m.t_h2 = m.t_h1; m.t_h1 = t_in;
        m.d_h2 = m.d_h1; m.d_h1 = d_in;
        m.cs = m.ph[0]; m.ce = ce; m.dot = carry;
    endtask

    task automatic compare(input string who, input model_t m, input logic [7:0] ph,
                           input logic cs, input logic ce, input logic dot,
                           input logic ta, input logic ra, input logic lk);
        check({who, ".ph_ce"},      ph,  m.ph);
        check({who, ".cyc_start"},  cs,  m.cs);
        check({who, ".cyc_end"},    ce,  m.ce);
        check({who, ".dot_ce"},     dot, m.dot);
        check({who, ".turbo_act"},  ta,  m.mode);
        check({who, ".dcrate_act"}, ra,  m.rate);
        check({who, ".locked"},     lk,  (m.lock == LOCK_CYC));
    endtask

    task automatic compare_all();
        compare("a", ma, {5'b0, bus_a.ph_ce}, bus_a.cyc_start, bus_a.cyc_end, bus_a.dot_ce,
                bus_a.turbo_act, bus_a.dcrate_act, bus_a.locked);
        compare("b", mb, {4'b0, bus_b.ph_ce}, bus_b.cyc_start, bus_b.cyc_end, bus_b.dot_ce,
                bus_b.turbo_act, bus_b.dcrate_act, bus_b.locked);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(ma, turbo_r, dcrate_r);
            model_step(mb, turbo_r, dcrate_r);
        end
        @(negedge clk);
        compare_all();
        // Independent interval properties on the 3-phase instance.
        if (bus_a.cyc_start) begin
            if (since_cs > 0) check("cyc_period_24_or_28", (since_cs == 24 || since_cs == 28), 1'b1);
            since_cs = 1;
        end else if (since_cs > 0) begin
            since_cs++;
        end
        if (bus_a.dot_ce) begin
            if (since_dot > 0) check("dot_spacing_2_to_4", (since_dot >= 2 && since_dot <= 4), 1'b1);
            since_dot = 1;
        end else if (since_dot > 0) begin
            since_dot++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pos(input int p, input int budget);
        int n;
        n = 0;
        while (ma.pos != p && n < budget) begin
            tick();
            n++;
        end
        if (ma.pos != p) check("wait_pos_timeout", 1'b0, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset(ma, 3, 28, 24);
        model_reset(mb, 4, 10, 8);
        since_cs = 0;
        since_dot = 0;
    endtask

    initial begin
        apply_reset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal mode from reset: lock exactly on the 16th cyc_end (edge 448).
        run(447);
        check("locked_before_16_cycles", bus_a.locked, 1'b0);
        run(1);
        check("locked_at_16_cycles", bus_a.locked, 1'b1);

        // Turbo request mid-cycle at cnt=5.
        wait_pos(5, 100);
        turbo_r = 1'b1;
        run(30);
        check("turbo_switch_drops_lock", bus_a.locked, 1'b0);
        run(16 * 24 + 40);
        check("turbo_act_after_switch", bus_a.turbo_act, 1'b1);
        check("turbo_relocked", bus_a.locked, 1'b1);
        turbo_r = 1'b0;
        run(500);

        // Short turbo glitch inside a normal cycle must be ignored.
        wait_pos(10, 100);
        turbo_r = 1'b1;
        run(3);
        turbo_r = 1'b0;
        run(60);
        check("glitch_turbo_act", bus_a.turbo_act, 1'b0);
        check("glitch_locked", bus_a.locked, 1'b1);

        // Dot-rate switch at carry boundaries.
        dcrate_r = 1'b1;
        run(40);
        check("dcrate_act_high", bus_a.dcrate_act, 1'b1);
        dcrate_r = 1'b0;
        run(40);

        // Asynchronous reset mid-cycle for one clk.
        wait_pos(15, 100);
        #2;
        apply_reset();
        #1;
        compare_all();
        tick();
        rst_n = 1'b1;
        run(447);
        check("relock_before_16_cycles", bus_a.locked, 1'b0);
        run(1);
        check("relock_at_16_cycles", bus_a.locked, 1'b1);

        // Randomized mode traffic.
        for (int s = 0; s < 60; s++) begin
            turbo_r  = 1'($urandom_range(0, 1));
            dcrate_r = 1'($urandom_range(0, 1));
            run($urandom_range(1, 60));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fal6567_phase_gen.md
Name: fal6567_phase_gen

Overview:
- Parametrised successor to the FAL6567 clock generator, implemented in fabric logic rather than MMCM outputs.
- From one fast master clock it produces NPH evenly spaced phase clock-enables per bus cycle, and a fractional (NCO) dot-clock enable.
- Normal/turbo cycle length and the dot rate are switched glitch-free, only at cycle and carry boundaries.
- Sits between the MMCM master clock and the VIC core / bus sequencer; it replaces BUFGMUX clock switching with enable-based timing.

Parameters:
- NPH, 3: number of phase enables per bus cycle (3 gives 0/120/240 degrees); legal range 1..8.
- DIV0, 28: master clocks per bus cycle in normal mode.
- DIV1, 24: master clocks per bus cycle in turbo mode.
- ACCW, 24: NCO accumulator width in bits.
- INC0, 24'h400000: NCO increment when dcrate_act=0.
- INC1, 24'h800000: NCO increment when dcrate_act=1.
- LOCK_CYC, 16: number of complete bus cycles in the current mode required before locked asserts.

Ports:
- clk, in, 1: master clock.
- rst_n, in, 1: reset.
- turbo, in, 1: turbo mode request; asynchronous to clk.
- dcrate, in, 1: dot-rate select request; asynchronous to clk.
- ph_ce, out, NPH: per-phase one-clk enable pulses.
- cyc_start, out, 1: equals ph_ce[0].
- cyc_end, out, 1: high on the last clk of a bus cycle.
- dot_ce, out, 1: NCO carry pulse.
- turbo_act, out, 1: cycle length currently in effect.
- dcrate_act, out, 1: NCO rate currently in effect.
- locked, out, 1: timing stable.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; cnt=0; acc=0; lock counter=0; synchronizer flops=0.
- First cycle after reset: the first clk after rst_n deasserts has cnt=0, so ph_ce[0] and cyc_start fire on that edge.
- Synchronizers: turbo and dcrate each pass through a 2-FF synchronizer. turbo_s and dcrate_s are valid 2 clks after the input changes.
- Divider:
  - cnt counts 0..D-1, where D = DIV1 if turbo_act else DIV0, then wraps to 0.
  - cyc_end = (cnt == D-1).
- Phase enables:
  - ph_ce[k] is a registered pulse, high for one clk when cnt == floor(k*D/NPH).
  - Offsets are elaboration-time constants for both D values.
  - DIV0=28, NPH=3 gives offsets 0, 9, 18. DIV1=24 gives 0, 8, 16.
  - Exactly NPH pulses per cycle; no two phases coincide.
- Outputs are registered: ph_ce, cyc_start and cyc_end reflect the cnt of the current clk with 1-clk latency. All taps move together, so relative phase is exact.
- Turbo switch:
  - turbo_act loads turbo_s only on a clk where cyc_end=1.
  - The next cycle starts at cnt=0 with the new D.
  - A request that toggles and returns before the boundary is ignored.
  - No truncated or stretched cycle is ever produced.
- NCO:
  - {carry, acc} = acc + INC, with INC = INC1 if dcrate_act else INC0.
  - dot_ce = carry, registered.
  - Arithmetic is ACCW bits, modulo 2^ACCW.
- Dot-rate switch: dcrate_act loads dcrate_s only on a clk where carry=1. The accumulator is never cleared, so there is no phase jump.
- Lock:
  - lock_cnt clears and locked drops to 0 on the clk when turbo_act or dcrate_act changes value.
  - Otherwise lock_cnt increments on each cyc_end, saturating at LOCK_CYC.
  - locked = (lock_cnt == LOCK_CYC).
- Simultaneous events: a turbo change and a dcrate change on the same clk are both applied, with a single lock restart.
- Reset mid-operation: rst_n low clears everything immediately, asynchronously, including pulses in flight.
- Elaboration checks: DIV0 >= NPH, DIV1 >= NPH and NPH >= 1, else $error.

Test Plan:
- Reset release, defaults, turbo=0: ph_ce pulses at cnt 0, 9, 18; period 28 clks; cyc_end at cnt 27; locked rises after 16 cyc_end pulses (~448 clks).
- turbo 0->1 asserted mid-cycle at cnt=5: the current cycle completes at 28 clks; next cycle is 24 clks with taps at 0, 8, 16; locked falls at the switch and re-asserts after 16 turbo cycles; no interval between cyc_start pulses other than 28 or 24.
- turbo glitch high for 3 clks at cnt=10, then low: turbo_act stays 0; locked stays 1; period stays 28.
- dcrate=0, INC0=2^22: dot_ce every 4 clks. Set dcrate=1: the switch takes effect at the next carry, then dot_ce every 2 clks; carry spacing never below 2 or above 4.
- rst_n pulled low mid-cycle at cnt=15 for 1 clk: all outputs 0 immediately (asynchronously); after release, cnt restarts at 0 and locked restarts its 16-cycle count.
- Parameter sweep NPH=4, DIV0=10, DIV1=8: taps at 0, 2, 5, 7 and 0, 2, 4, 6; NPH=11 with DIV1=8 must fail elaboration.
